// File: rtl/rr_pass_arbiter.sv
// rr_pass_arbiter: round-robin owner of a shared single-bit pass-through (q = d[owner]).
// Grants one requester at a time for at most HOLD_MAX cycles, with one IDLE bubble
// between grants, and keeps a saturating count of transferred (q_valid) cycles.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   req[N]    per-requester request, level-sensitive
//   d[N]      per-requester data bit
//   last[N]   per-requester end-of-burst marker (only the owner's bit is used)
//   gnt[N]    one-hot grant, registered
//   owner     current / most recent owner index, registered
//   q         d[owner] while q_valid, else 0 (combinational)
//   q_valid   GRANT state and owner still requesting (combinational)
//   busy      high in GRANT, registered
//   xfer_cnt  saturating count of q_valid cycles, registered
module rr_pass_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         d,
    input  logic [N-1:0]         last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 q,
    output logic                 q_valid,
    output logic                 busy,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [N-1:0]    gnt_d;
    logic [OW-1:0]   owner_d;
    logic            busy_d;
    logic [CNT_W-1:0] xfer_d;
    logic [OW-1:0]   sel_c;
    logic            rel_c;

    // First requesting index at or above ptr, wrapping modulo N.
    always_comb begin
        logic [OW:0] idx;
        logic        found;
        sel_c = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (OW+1)'(i);
            if (idx >= (OW+1)'(N)) begin
                idx = idx - (OW+1)'(N);
            end
            if (!found && req[idx[OW-1:0]]) begin
                sel_c = idx[OW-1:0];
                found = 1'b1;
            end
        end
    end

    // Shared datapath: owner's bit passes through only while it is still requesting.
    assign q_valid = (state_q == GRANT) && req[owner];
    assign q       = q_valid & d[owner];

    // Owner gives up the grant on dropped request, end of burst, or hold limit.
    assign rel_c = !req[owner] || last[owner] || (hcnt_q == HW'(HOLD_MAX));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt;
        owner_d = owner;
        busy_d  = busy;
        xfer_d  = xfer_cnt;

        if (q_valid && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_d = xfer_cnt + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << sel_c;
                    owner_d = sel_c;
                    hcnt_d  = HW'(1);
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (rel_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hcnt_d  = '0;
                    ptr_d   = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
                end else begin
                    hcnt_d  = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hcnt_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hcnt_q   <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hcnt_q   <= hcnt_d;
            gnt      <= gnt_d;
            owner    <= owner_d;
            busy     <= busy_d;
            xfer_cnt <= xfer_d;
        end
    end

endmodule

// File: tb/tb_rr_pass_arbiter.sv
// Self-checking bench for rr_pass_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_pass_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned HM  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned OW  = $clog2(N);
    localparam int          CAP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, d, last;
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          q, q_valid, busy;
    logic [CW-1:0] xfer_cnt;

    rr_pass_arbiter #(.N(N), .HOLD_MAX(HM), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .d        (d),
        .last     (last),
        .gnt      (gnt),
        .owner    (owner),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic          m_busy;
    logic [OW-1:0] m_owner;
    logic [OW-1:0] m_ptr;
    int            m_hold;
    int            m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = '0;
        m_ptr   = '0;
        m_hold  = 0;
        m_cnt   = 0;
    endtask

    // One clock: drive inputs, check mid-cycle against the model, advance the model at the edge.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] dd, input logic [N-1:0] l);
        logic [N-1:0]  eg;
        logic          eqv, eq;
        logic [OW-1:0] ix;
        req  = r;
        d    = dd;
        last = l;
        #4;
        eg  = m_busy ? (N'(1) << m_owner) : '0;
        eqv = m_busy && r[m_owner];
        eq  = eqv && dd[m_owner];
        check("gnt",      32'(gnt),      32'(eg));
        check("owner",    32'(owner),    32'(m_owner));
        check("busy",     32'(busy),     32'(m_busy));
        check("q_valid",  32'(q_valid),  32'(eqv));
        check("q",        32'(q),        32'(eq));
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        if (eqv && m_cnt < CAP) m_cnt++;
        if (m_busy) begin
            if (!r[m_owner] || l[m_owner] || m_hold == int'(HM)) begin
                m_busy = 1'b0;
                m_hold = 0;
                m_ptr  = OW'((int'(m_owner) + 1) % N);
            end else begin
                m_hold++;
            end
        end else if (r != '0) begin
            for (int k = N - 1; k >= 0; k--) begin
                ix = OW'((int'(m_ptr) + k) % N);
                if (r[ix]) m_owner = ix;
            end
            m_busy = 1'b1;
            m_hold = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before the next edge.
    task automatic mid_reset();
        #1;
        rst = 1'b1;
        #1;
        check("rst_gnt",   32'(gnt),      32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_qv",    32'(q_valid),  32'd0);
        check("rst_q",     32'(q),        32'd0);
        check("rst_owner", 32'(owner),    32'd0);
        check("rst_xfer",  32'(xfer_cnt), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int     order[$];
        logic   pb;
        logic   seen;
        logic [N-1:0] r, dd, l;

        rst  = 1'b1;
        req  = '0;
        d    = '0;
        last = '0;
        model_reset();
        #2;
        check("init_gnt",  32'(gnt),      32'd0);
        check("init_busy", 32'(busy),     32'd0);
        check("init_qv",   32'(q_valid),  32'd0);
        check("init_xfer", 32'(xfer_cnt), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Single requester with its data held high
        repeat (10) cycle(4'b0100, 4'b0100, 4'b0000);
        check("single_xfer8", 32'(xfer_cnt), 32'd8);
        check("single_owner", 32'(owner),    32'd2);

        // Full contention: grant order 0,1,2,3,0
        mid_reset();
        pb = 1'b0;
        repeat (25) begin
            cycle(4'b1111, N'($urandom), 4'b0000);
            if (busy && !pb) order.push_back(int'(owner));
            pb = busy;
        end
        check("order_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            check("order", 32'(order[i]), 32'(i % 4));
        end

        // Early release via last, then next grant starts at 2
        mid_reset();
        cycle(4'b0010, 4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0010, 4'b0010);
        cycle(4'b1111, 4'b0000, 4'b0000);
        check("early_owner", 32'(owner), 32'd2);
        check("early_gnt",   32'(gnt),   32'b0100);

        // Owner 3 drops its request in its second grant cycle
        mid_reset();
        cycle(4'b1000, 4'b1000, 4'b0000);
        cycle(4'b1000, 4'b1000, 4'b0000);
        cycle(4'b0000, 4'b1000, 4'b0000);
        cycle(4'b0000, 4'b1000, 4'b0000);
        check("drop_xfer", 32'(xfer_cnt), 32'd1);

        // Saturation, then reset in the middle of a grant
        mid_reset();
        repeat (25) cycle(4'b0001, 4'b0001, 4'b0000);
        check("sat_xfer", 32'(xfer_cnt), 32'd15);
        seen = busy;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(4'b0001, 4'b0001, 4'b0000);
            seen = busy;
        end
        check("sat_wait_busy", 32'(seen), 32'd1);
        mid_reset();
        cycle(4'b1111, 4'b0000, 4'b0000);
        check("post_rst_owner", 32'(owner), 32'd0);
        check("post_rst_gnt",   32'(gnt),   32'b0001);

        // Random traffic with occasional asynchronous resets
        repeat (400) begin
            r  = N'($urandom);
            dd = N'($urandom);
            l  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 59) == 0) mid_reset();
            else cycle(r, dd, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_pass_arbiter.md
Name: rr_pass_arbiter

Overview:
Round-robin controller that shares the single-bit pass-through datapath `q = d` between N requesters.
- Grants one requester at a time, bounded by a hold limit.
- Forwards the granted requester's data bit to `q` combinationally; `q` is forced to 0 whenever no grant is active.
- Sits between N producer lanes and one shared single-bit consumer, and keeps a saturating transfer counter for debug.

Parameters:
- N, 4: number of requesters; legal range 2..16.
- HOLD_MAX, 8: maximum consecutive GRANT cycles per grant; must be ≥1.
- CNT_W, 16: width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset.
- req  input  N  per-requester request; level-sensitive.
- d  input  N  per-requester data bit.
- last  input  N  per-requester end-of-burst marker; sampled only for the current owner.
- gnt  output  N  one-hot grant; registered.
- owner  output  clog2(N)  index of the current or last owner; registered.
- q  output  1  shared data: d[owner] when q_valid is high, else 0; combinational.
- q_valid  output  1  high when in GRANT and req[owner] is high; combinational.
- busy  output  1  high when state is GRANT; registered.
- xfer_cnt  output  CNT_W  count of q_valid cycles since reset; saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (rst=1, takes effect immediately, independent of clk):
  - state=IDLE, gnt=0, owner=0, busy=0, q=0, q_valid=0.
  - Round-robin pointer ptr=0, hold counter hcnt=0, xfer_cnt=0.
  - Reset asserted mid-grant drops gnt the same cycle, with no completion.
- States: IDLE and GRANT only.
- IDLE:
  - If any req bit is high, select the first requester with req high, searching from ptr upward and wrapping modulo N.
  - At the next edge: state=GRANT, gnt=onehot(sel), owner=sel, hcnt=1, busy=1.
  - If no req bit is high, remain in IDLE.
- GRANT, release condition (combinational, evaluated each cycle) = req[owner]==0 OR last[owner]==1 OR hcnt==HOLD_MAX.
- GRANT, no release: hcnt increments at the edge; gnt and owner are unchanged.
- GRANT, release:
  - The releasing cycle itself still has gnt asserted; q_valid in that cycle follows the q_valid rule.
  - At the next edge: state=IDLE, gnt=0, busy=0, hcnt=0, ptr=(owner+1) mod N; owner keeps its value.
- Mandatory bubble: exactly one IDLE cycle between consecutive grants, even when other requests are pending. Worst-case request-to-grant latency is N·(HOLD_MAX+1) cycles.
- q_valid and q:
  - Request-to-grant latency is 1 cycle: req seen in IDLE at edge k gives gnt at cycle k+1.
  - q = q_valid ? d[owner] : 1'b0, with no registering of d.
- Requests from non-owners during GRANT are ignored until the next IDLE arbitration.
- Simultaneous last[owner]=1 and hcnt==HOLD_MAX: a single release, with identical effect to either condition alone.
- xfer_cnt increments on each edge where q_valid=1 and holds at 2^CNT_W−1.
- hcnt width: clog2(HOLD_MAX+1); it never exceeds HOLD_MAX.

Test Plan (N=4, HOLD_MAX=4, CNT_W=4):
- Reset: assert rst mid-cycle → gnt=0000, q=0, q_valid=0, busy=0, owner=0, xfer_cnt=0 before the next clk edge.
- Single requester: req=0100, d[2]=1 held → gnt=0100 for cycles 1–4 with q=1 and q_valid=1; cycle 5 IDLE with q=0; regrant to 2 at cycle 6; xfer_cnt=8 after cycle 9.
- Full contention: req=1111 held → grant order 0,1,2,3,0; each grant lasts 4 cycles; each grant is followed by one IDLE cycle with gnt=0000.
- Early release via last: req=0010, last[1]=1 in the 2nd GRANT cycle → gnt=0010 for exactly 2 cycles, then IDLE; ptr=2, so with req=1111 next the grant goes to 2.
- Request drop: owner 3 drops req in GRANT cycle 2 → in that cycle q_valid=0 and q=0 regardless of d[3]; next cycle IDLE; xfer_cnt has advanced by 1.
- Reset mid-grant plus saturation: run req=0001 until xfer_cnt=15 → it stays at 15; assert rst during GRANT → gnt=0000 immediately; after release, the first grant goes to requester 0 (ptr=0).
